// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad scanner with whole-frame debounce; optional auto-repeat via KEYPAD_AUTOREPEAT_EN
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int SLOT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // One frame counter serves debounce (press/release) and the repeat cadence,
  // which counts from 0 up to REPEAT_DELAY+REPEAT_RATE and folds back.
  localparam int RPT_SPAN = REPEAT_DELAY + REPEAT_RATE;
  localparam int CNT_MAX  = (DEBOUNCE_FRAMES > RPT_SPAN) ? DEBOUNCE_FRAMES : RPT_SPAN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_e;

  logic [3:0]        row_s1_q, row_s2_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_q;
  logic [3:0]        col_out_q;
  logic [15:0]       acc_q;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        cand_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q, key_held_q, multi_key_q;

  logic              slot_end, frame_end;
  logic [15:0]       frame_keys;
  logic [4:0]        n_keys;
  logic [3:0]        hit_code;
  logic              res_none, res_single, res_multi;
  logic [CNT_W-1:0]  cnt_inc;

  assign slot_end   = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign frame_end  = slot_end && (col_q == 2'd3);
  assign res_none   = (n_keys == 5'd0);
  assign res_single = (n_keys == 5'd1);
  assign res_multi  = (n_keys > 5'd1);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // Two-flop synchronizer for the asynchronous active-low row lines
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  // Slot timer, column rotation and accumulation of pressed keys over a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= '0;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      acc_q     <= 16'h0000;
    end else if (slot_end) begin
      slot_q    <= '0;
      col_q     <= col_q + 2'd1;
      col_out_q <= {col_out_q[2:0], col_out_q[3]};
      acc_q     <= frame_end ? 16'h0000 : frame_keys;
    end else begin
      slot_q    <= slot_q + SLOT_W'(1);
    end
  end

  // Merge the current column's rows into the frame and classify it
  always_comb begin
    frame_keys = acc_q;
    for (int r = 0; r < 4; r++) begin
      frame_keys[{r[1:0], col_q}] = ~row_s2_q[r];
    end
    n_keys   = 5'd0;
    hit_code = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (frame_keys[k]) begin
        n_keys   = n_keys + 5'd1;
        hit_code = k[3:0];
      end
    end
  end

  // Per-frame debounce FSM with registered strobe and level outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      multi_key_q <= frame_end && res_multi;
      if (frame_end) begin
        case (state_q)
          IDLE: begin
            if (res_single) begin
              state_q <= CONFIRM;
              cand_q  <= hit_code;
              cnt_q   <= CNT_W'(1);
            end
          end
          CONFIRM: begin
            if (res_single && (hit_code == cand_q)) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
                state_q     <= HELD;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (res_none) begin
              state_q <= RELEASE;
              cnt_q   <= CNT_W'(1);
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (res_single && (hit_code == key_code_q)) begin
              if (cnt_inc == CNT_W'(RPT_SPAN)) begin
                key_valid_q <= 1'b1;
                cnt_q       <= CNT_W'(REPEAT_DELAY);
              end else begin
                key_valid_q <= (cnt_inc == CNT_W'(REPEAT_DELAY));
                cnt_q       <= cnt_inc;
              end
            end
`endif
            else begin
              cnt_q <= '0;
            end
          end
          RELEASE: begin
            if (res_none) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= HELD;
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - randomized self-checking bench for keypad_scan against a frame-level model
module tb_keypad_scan;

  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int RD    = 5;
  localparam int RR    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  bit m_held;
  int m_streak, m_cand, m_code, m_rel, m_since;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE_FRAMES(DF),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .multi_key(multi_key)
  );

  // Physical keypad: a row reads low when a pressed key in it sits on a driven column
  always_comb begin
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && keys[4*r+c]) rows[r] = 1'b0;
    row_in = rows;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_streak = 0; m_cand = 0; m_code = 0; m_rel = 0; m_since = 0;
  endtask

  // Frame-level reference: result is the set of keys down for the whole frame
  task automatic model_frame(input logic [15:0] k, output bit v, output bit multi);
    int n;
    int c;
    n = $countones(k);
    c = 0;
    for (int i = 0; i < 16; i++) if (k[i]) c = i;
    v = 0;
    multi = (n > 1);
    if (!m_held) begin
      if (m_streak > 0 && n == 1 && c == m_cand) begin
        m_streak++;
        if (m_streak == DF) begin
          v = 1; m_held = 1; m_code = c; m_streak = 0; m_rel = 0; m_since = 0;
        end
      end else if (m_streak == 0 && n == 1) begin
        m_cand = c; m_streak = 1;
      end else begin
        m_streak = 0;
      end
    end else if (n == 0) begin
      m_since = 0;
      m_rel++;
      if (m_rel == DF) begin m_held = 0; m_rel = 0; end
    end else begin
      if (m_rel == 0 && n == 1 && c == m_code) begin
        m_since++;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_since >= RD && ((m_since - RD) % RR) == 0) v = 1;
`endif
      end else begin
        m_since = 0;
      end
      m_rel = 0;
    end
  endtask

  task automatic do_reset(input int n);
    logic [6:0] outs;
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_reset();
    outs = {key_code, key_valid, key_held, multi_key};
    check("rst_col_out", col_out, 4'b1110);
    check("rst_outputs", outs, 7'd0);
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] k);
    bit ev, em;
    logic [3:0] exp_col;
    logic [1:0] quiet;
    logic [3:0] exp_code;
    keys = k;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << ((i / SD) % 4));
      check("col_out", col_out, exp_col);
      if (i < FRAME) begin
        quiet = {key_valid, multi_key};
        check("quiet", quiet, 2'b00);
      end
    end
    model_frame(k, ev, em);
    exp_code = m_code[3:0];
    check("key_valid", key_valid, ev);
    check("multi_key", multi_key, em);
    check("key_held", key_held, m_held);
    check("key_code", key_code, exp_code);
  endtask

  initial begin
    logic [15:0] k;
    int sel, len, a, b;
    reset = 1'b1;
    keys  = 16'h0000;
    model_reset();
    do_reset(3);
    run_frame(16'h0000);

    // single press of key 6 then release
    repeat (10) run_frame(16'h0040);
    repeat (4) run_frame(16'h0000);

    // bounce, then steady hold
    for (int i = 0; i < 6; i++) run_frame((i % 2) ? 16'h0000 : 16'h0040);
    repeat (5) run_frame(16'h0040);
    repeat (4) run_frame(16'h0000);

    // keys 0 and 5 together, then key 0 alone
    repeat (4) run_frame(16'h0021);
    repeat (5) run_frame(16'h0001);
    repeat (4) run_frame(16'h0000);

    // key 9 confirmed, reset mid-frame while still held, re-confirm
    repeat (4) run_frame(16'h0200);
    repeat (7) @(posedge clk);
    do_reset(1);
    repeat (5) run_frame(16'h0200);
    repeat (4) run_frame(16'h0000);

    // key 15 held 12 frames after confirm (repeat cadence when enabled)
    repeat (DF + 12) run_frame(16'h8000);
    repeat (4) run_frame(16'h0000);

    // randomized episodes
    for (int it = 0; it < 220; it++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 8);
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      k   = 16'h0001 << a;
      if (sel <= 4) begin
        repeat (len) run_frame(k);
      end else if (sel <= 6) begin
        repeat ((len + 1) / 2) run_frame(16'h0000);
      end else if (sel == 7) begin
        k = k | (16'h0001 << b);
        repeat ((len + 2) / 3) run_frame(k);
      end else if (sel == 8) begin
        for (int j = 0; j < len; j++) run_frame((j % 2) ? 16'h0000 : k);
      end else begin
        keys = k;
        repeat ($urandom_range(1, FRAME - 1)) @(posedge clk);
        do_reset($urandom_range(1, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
